sram_ab_arbiter: RTL

//  Shares one sram_ab-style word SRAM (port A read-only, registered 2-cycle read; port B masked write)

---
 rtl/sram_ab_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_ab_arbiter.sv
// sram_ab_arbiter: round-robin sharing of one sram_ab word SRAM among
// NUM_REQ clients, with optional zero-fill of every word after reset.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_valid/rd_addr    per-client read requests (packed, client i at i*ADDR_W)
//   rd_ready            one-hot read grant (combinational)
//   rsp_valid/rsp_rdata one-hot read-data strobe and shared read data
//   wr_valid/wr_addr/wr_wdata/wr_wmask  per-client masked write requests
//   wr_ready            one-hot write grant (combinational)
//   init_done           high once clients are being served
//   a_en/a_re/a_addr    SRAM port A (read) controls; a_rdata/a_rvalid back
//   b_en/b_we/b_addr/b_wdata/b_wmask    SRAM port B (write) controls
//   perf_*              grant/stall counters, only with SRAM_ARB_PERF_CNT_EN
//
// Define SRAM_ARB_PERF_CNT_EN to add the performance counter outputs.
module sram_ab_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              rd_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]       rd_addr,
    output logic [NUM_REQ-1:0]              rd_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    input  logic [NUM_REQ-1:0]              wr_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]       wr_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]   wr_wmask,
    output logic [NUM_REQ-1:0]              wr_ready,
    output logic                            init_done,
    output logic                            a_en,
    output logic                            a_re,
    output logic [ADDR_W-1:0]               a_addr,
    input  logic [DATA_W-1:0]               a_rdata,
    input  logic                            a_rvalid,
    output logic                            b_en,
    output logic                            b_we,
    output logic [ADDR_W-1:0]               b_addr,
    output logic [DATA_W-1:0]               b_wdata,
    output logic [(DATA_W/8)-1:0]           b_wmask
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_rd_grant,
    output logic [31:0]                     perf_rd_stall,
    output logic [31:0]                     perf_wr_grant,
    output logic [31:0]                     perf_wr_stall
`endif
);
    localparam int BYTE_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    // Returns {found, index}: first valid at or above ptr, else first below.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && v[i] && (IDX_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && v[i] && (IDX_W'(i) < ptr)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
        return (w == LAST) ? '0 : w + 1'b1;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  rr_rd_q, rr_rd_d;
    logic [IDX_W-1:0]  rr_wr_q, rr_wr_d;
    // Two-stage grant-ID pipe matching the SRAM read latency.
    logic              id0_v_q, id0_v_d, id1_v_q, id1_v_d;
    logic [IDX_W-1:0]  id0_idx_q, id0_idx_d, id1_idx_q, id1_idx_d;

    logic [IDX_W:0]    rd_pick, wr_pick;
    logic              rd_any, wr_any;
    logic [IDX_W-1:0]  rd_win, wr_win;
    logic              run, clr;

    assign rd_pick = rr_pick(rd_valid, rr_rd_q);
    assign wr_pick = rr_pick(wr_valid, rr_wr_q);
    assign rd_any  = rd_pick[IDX_W];
    assign wr_any  = wr_pick[IDX_W];
    assign rd_win  = rd_pick[IDX_W-1:0];
    assign wr_win  = wr_pick[IDX_W-1:0];

    // Outputs are held at their reset values while rst is high.
    assign run = !rst && (state_q == S_RUN);
    assign clr = !rst && (state_q == S_CLEAR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = S_RUN;
        end
        rr_rd_d   = (run && rd_any) ? rr_next(rd_win) : rr_rd_q;
        rr_wr_d   = (run && wr_any) ? rr_next(wr_win) : rr_wr_q;
        id0_v_d   = run && rd_any;
        id0_idx_d = rd_win;
        id1_v_d   = id0_v_q;
        id1_idx_d = id0_idx_q;
    end

    always_comb begin
        rd_ready  = '0;
        wr_ready  = '0;
        a_addr    = '0;
        b_addr    = '0;
        b_wdata   = '0;
        b_wmask   = '0;
        if (run && rd_any) rd_ready = NUM_REQ'(1) << rd_win;
        if (run && wr_any) wr_ready = NUM_REQ'(1) << wr_win;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_win == IDX_W'(i)) a_addr = rd_addr[i*ADDR_W +: ADDR_W];
            if (wr_win == IDX_W'(i)) begin
                b_addr  = wr_addr[i*ADDR_W +: ADDR_W];
                b_wdata = wr_wdata[i*DATA_W +: DATA_W];
                b_wmask = wr_wmask[i*BYTE_W +: BYTE_W];
            end
        end
        if (clr) begin
            b_addr  = cnt_q;
            b_wdata = '0;
            b_wmask = '1;
        end
        a_en      = run && rd_any;
        a_re      = a_en;
        b_en      = clr || (run && wr_any);
        b_we      = b_en;
        init_done = rst ? (CLEAR_ON_RESET == 0) : (state_q == S_RUN);
        rsp_valid = '0;
        rsp_rdata = '0;
        // Unclaimed SRAM data (e.g. across a reset) is dropped here.
        if (!rst && a_rvalid && id1_v_q) begin
            rsp_valid = NUM_REQ'(1) << id1_idx_q;
            rsp_rdata = a_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            cnt_q     <= '0;
            rr_rd_q   <= '0;
            rr_wr_q   <= '0;
            id0_v_q   <= 1'b0;
            id0_idx_q <= '0;
            id1_v_q   <= 1'b0;
            id1_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_rd_q   <= rr_rd_d;
            rr_wr_q   <= rr_wr_d;
            id0_v_q   <= id0_v_d;
            id0_idx_q <= id0_idx_d;
            id1_v_q   <= id1_v_d;
            id1_idx_q <= id1_idx_d;
        end
    end

`ifdef SRAM_ARB_PERF_CNT_EN
    function automatic logic [31:0] popcnt(input logic [NUM_REQ-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < NUM_REQ; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] rd_grant_q, rd_grant_d, rd_stall_q, rd_stall_d;
    logic [31:0] wr_grant_q, wr_grant_d, wr_stall_q, wr_stall_d;

    always_comb begin
        rd_grant_d = rd_grant_q;
        rd_stall_d = rd_stall_q;
        wr_grant_d = wr_grant_q;
        wr_stall_d = wr_stall_q;
        if (run) begin
            rd_grant_d = rd_grant_q + 32'(rd_any);
            wr_grant_d = wr_grant_q + 32'(wr_any);
            rd_stall_d = sat_add(rd_stall_q, popcnt(rd_valid & ~rd_ready));
            wr_stall_d = sat_add(wr_stall_q, popcnt(wr_valid & ~wr_ready));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_grant_q <= '0;
            rd_stall_q <= '0;
            wr_grant_q <= '0;
            wr_stall_q <= '0;
        end else begin
            rd_grant_q <= rd_grant_d;
            rd_stall_q <= rd_stall_d;
            wr_grant_q <= wr_grant_d;
            wr_stall_q <= wr_stall_d;
        end
    end

    assign perf_rd_grant = rd_grant_q;
    assign perf_rd_stall = rd_stall_q;
    assign perf_wr_grant = wr_grant_q;
    assign perf_wr_stall = wr_stall_q;
`endif
endmodule
